// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: a table of saturating counters indexed by
// branch address XOR global history, swept to weakly-not-taken after reset.
module gshare_predictor #(
  parameter int IDX_W  = 10,
  parameter int HIST_W = 4,   // must not exceed IDX_W
  parameter int CTR_W  = 2    // must be at least 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [IDX_W-1:0]  pred_addr,
  output logic              pred_ready,
  output logic              pred_out_valid,
  output logic              pred_taken,
  output logic [CTR_W-1:0]  pred_ctr,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  output logic [HIST_W-1:0] ghr
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  // Handshake: a lookup is accepted on any rising edge where pred_valid=1 and
  // pred_ready=1; its result appears with pred_out_valid=1 one cycle later.
  // Updates are accepted whenever upd_valid=1 in RUN; there is no backpressure.
  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] sweep;
  logic [CTR_W-1:0] ctr_mem [DEPTH];

  logic             run;
  logic             upd_fire;
  logic [IDX_W-1:0] lk_idx;
  logic [CTR_W-1:0] upd_old;
  logic [CTR_W-1:0] upd_new;
  logic [CTR_W-1:0] lk_ctr;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [CTR_W-1:0] mem_wdata;

  always_comb begin
    run      = (state == RUN);
    upd_fire = run && upd_valid;
    lk_idx   = pred_addr ^ IDX_W'(ghr);
    upd_old  = ctr_mem[upd_idx];
    upd_new  = upd_old;
    if (upd_taken) begin
      if (upd_old != CTR_MAX) upd_new = upd_old + CTR_W'(1);
    end else begin
      if (upd_old != '0) upd_new = upd_old - CTR_W'(1);
    end
    // Same-cycle update to the looked-up entry: forward the new value.
    lk_ctr = (upd_fire && (upd_idx == lk_idx)) ? upd_new : ctr_mem[lk_idx];
  end

  always_comb begin
    mem_we    = !rst && (!run || upd_valid);
    mem_waddr = run ? upd_idx : sweep;
    mem_wdata = run ? upd_new : CTR_WNT;
  end

  always_ff @(posedge clk) begin
    if (mem_we) ctr_mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= INIT;
      sweep          <= '0;
      ghr            <= '0;
      pred_ready     <= 1'b0;
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_ctr       <= '0;
      pred_idx       <= '0;
    end else begin
      case (state)
        INIT: begin
          pred_out_valid <= 1'b0;
          sweep          <= sweep + IDX_W'(1);
          if (&sweep) begin
            state      <= RUN;
            pred_ready <= 1'b1;
          end
        end
        RUN: begin
          pred_out_valid <= pred_valid;
          if (pred_valid) begin
            pred_taken <= lk_ctr[CTR_W-1];
            pred_ctr   <= lk_ctr;
            pred_idx   <= lk_idx;
          end
          if (upd_valid) ghr <= HIST_W'({ghr, upd_taken});
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
